// File: rtl/and4_gate.sv
// Four-input AND, replicated per lane. Each lane has a combinational output
// and a valid-qualified registered copy. Lane 0 also tracks minterm coverage.
module and4_gate #(
  parameter int unsigned LANES = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             clr,
  input  logic [LANES-1:0] a,
  input  logic [LANES-1:0] b,
  input  logic [LANES-1:0] c,
  input  logic [LANES-1:0] d,
  output logic [LANES-1:0] f,
  output logic [LANES-1:0] f_q,
  output logic             out_valid,
  output logic [15:0]      seen,
  output logic             all_seen,
  output logic [CNT_W-1:0] hi_count
);

  localparam int unsigned MT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [3:0]       minterm;
  logic [MT_W-1:0]  seen_nxt;
  logic [CNT_W-1:0] hi_count_nxt;

  assign f       = a & b & c & d;
  assign minterm = {a[0], b[0], c[0], d[0]};

  // Lane-0 coverage and saturating hit counter; clr wins over capture
  always_comb begin
    seen_nxt     = seen;
    hi_count_nxt = hi_count;
    if (clr) begin
      seen_nxt     = '0;
      hi_count_nxt = '0;
    end else if (in_valid) begin
      seen_nxt = seen | (MT_W'(1) << minterm);
      if (f[0] && (hi_count != CNT_MAX)) begin
        hi_count_nxt = hi_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q       <= '0;
      out_valid <= 1'b0;
      seen      <= '0;
      all_seen  <= 1'b0;
      hi_count  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        f_q <= f;
      end
      seen     <= seen_nxt;
      // Looks at the next value so it rises with the final minterm
      all_seen <= (seen_nxt == 16'hFFFF);
      hi_count <= hi_count_nxt;
    end
  end

endmodule

// File: tb/tb_and4_gate.sv
// Directed bench for and4_gate: one 4-lane instance, one single-lane instance
// and one single-lane instance with a 2-bit counter, all driven together.
module tb_and4_gate;

  logic       clk = 1'b0;
  logic       rst, in_valid, clr;
  logic [3:0] a4, b4, c4, d4;

  logic [3:0]  w_f, w_fq;
  logic        w_ov, w_all;
  logic [15:0] w_seen, w_hi;
  logic [0:0]  o_f, o_fq;
  logic        o_ov, o_all;
  logic [15:0] o_seen, o_hi;
  logic [0:0]  s_f, s_fq;
  logic        s_ov, s_all;
  logic [15:0] s_seen;
  logic [1:0]  s_hi;

  int errors = 0;
  int checks = 0;

  logic [3:0]  exp_q[$];
  logic [3:0]  m_fq;
  logic        m_ov, m_all;
  logic [15:0] m_seen, m_hi;
  logic [1:0]  m_sat;

  always #5 clk = ~clk;

  and4_gate #(.LANES(4), .CNT_W(16)) u_wide (
    .clk(clk), .rst(rst), .in_valid(in_valid), .clr(clr),
    .a(a4), .b(b4), .c(c4), .d(d4),
    .f(w_f), .f_q(w_fq), .out_valid(w_ov), .seen(w_seen),
    .all_seen(w_all), .hi_count(w_hi)
  );

  and4_gate #(.LANES(1), .CNT_W(16)) u_one (
    .clk(clk), .rst(rst), .in_valid(in_valid), .clr(clr),
    .a(a4[0]), .b(b4[0]), .c(c4[0]), .d(d4[0]),
    .f(o_f), .f_q(o_fq), .out_valid(o_ov), .seen(o_seen),
    .all_seen(o_all), .hi_count(o_hi)
  );

  and4_gate #(.LANES(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .clr(clr),
    .a(a4[0]), .b(b4[0]), .c(c4[0]), .d(d4[0]),
    .f(s_f), .f_q(s_fq), .out_valid(s_ov), .seen(s_seen),
    .all_seen(s_all), .hi_count(s_hi)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one vector at negedge, check f, update the model, check after the edge
  task automatic step(input logic [3:0] va, input logic [3:0] vb, input logic [3:0] vc,
                      input logic [3:0] vd, input logic v, input logic cl, input logic r);
    logic [3:0] fx;
    logic [3:0] mt;
    @(negedge clk);
    a4 = va; b4 = vb; c4 = vc; d4 = vd;
    in_valid = v; clr = cl; rst = r;
    fx = va & vb & vc & vd;
    mt = {va[0], vb[0], vc[0], vd[0]};
    #1;
    chk("f_wide", 32'(w_f), 32'(fx));
    chk("f_one", 32'(o_f), 32'(fx[0]));
    if (r) begin
      exp_q.delete();
      m_fq = '0; m_ov = 1'b0; m_seen = '0; m_all = 1'b0; m_hi = '0; m_sat = '0;
    end else begin
      m_ov = v;
      if (v) exp_q.push_back(fx);
      if (cl) begin
        m_seen = '0; m_hi = '0; m_sat = '0;
      end else if (v) begin
        m_seen[mt] = 1'b1;
        if (fx[0] && m_hi != 16'hFFFF) m_hi = m_hi + 16'd1;
        if (fx[0] && m_sat != 2'd3) m_sat = m_sat + 2'd1;
      end
      m_all = (m_seen == 16'hFFFF);
    end
    @(posedge clk);
    #1;
    if (m_ov) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL scoreboard_empty: got empty queue expected one entry");
      end else begin
        m_fq = exp_q.pop_front();
      end
    end
    chk("out_valid_wide", 32'(w_ov), 32'(m_ov));
    chk("out_valid_one", 32'(o_ov), 32'(m_ov));
    chk("f_q_wide", 32'(w_fq), 32'(m_fq));
    chk("f_q_one", 32'(o_fq), 32'(m_fq[0]));
    chk("seen_wide", 32'(w_seen), 32'(m_seen));
    chk("seen_one", 32'(o_seen), 32'(m_seen));
    chk("all_seen_wide", 32'(w_all), 32'(m_all));
    chk("all_seen_one", 32'(o_all), 32'(m_all));
    chk("hi_count_wide", 32'(w_hi), 32'(m_hi));
    chk("hi_count_one", 32'(o_hi), 32'(m_hi));
    chk("hi_count_sat", 32'(s_hi), 32'(m_sat));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] sat_exp [6];
    logic [3:0] iv;
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    rst = 1'b1; in_valid = 1'b0; clr = 1'b0;
    a4 = '0; b4 = '0; c4 = '0; d4 = '0;
    m_fq = '0; m_ov = 1'b0; m_seen = '0; m_all = 1'b0; m_hi = '0; m_sat = '0;

    // Reset state
    step(4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1);
    step(4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1);
    chk("reset_seen", 32'(w_seen), 32'h0);
    chk("reset_f_q", 32'(w_fq), 32'h0);

    // Exhaustive ascending sweep on lane 0
    for (int i = 0; i < 16; i++) begin
      iv = 4'(i);
      step({3'b0, iv[3]}, {3'b0, iv[2]}, {3'b0, iv[1]}, {3'b0, iv[0]}, 1'b1, 1'b0, 1'b0);
    end
    chk("sweep_seen", 32'(o_seen), 32'hFFFF);
    chk("sweep_all_seen", 32'(o_all), 32'h1);
    chk("sweep_hi_count", 32'(o_hi), 32'h1);
    chk("sweep_f_q", 32'(o_fq), 32'h1);

    // Reset mid-sweep; f still follows inputs while rst is high
    for (int i = 0; i < 8; i++) begin
      iv = 4'(i);
      step({3'b0, iv[3]}, {3'b0, iv[2]}, {3'b0, iv[1]}, {3'b0, iv[0]}, 1'b1, 1'b0, 1'b0);
    end
    step(4'h1, 4'h1, 4'h1, 4'h1, 1'b1, 1'b0, 1'b1);
    chk("midreset_seen", 32'(o_seen), 32'h0);
    chk("midreset_out_valid", 32'(o_ov), 32'h0);

    // Valid gating
    for (int i = 0; i < 5; i++) step(4'h1, 4'h1, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0);
    chk("gate_f_q_held", 32'(o_fq), 32'h0);
    for (int i = 0; i < 3; i++) step(4'h1, 4'h1, 4'h1, 4'h1, 1'b1, 1'b0, 1'b0);
    chk("gate_hi_count", 32'(o_hi), 32'h3);
    chk("gate_f_q", 32'(o_fq), 32'h1);

    // Clear versus capture with seen = 00FF
    step(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      iv = 4'(i);
      step({3'b0, iv[3]}, {3'b0, iv[2]}, {3'b0, iv[1]}, {3'b0, iv[0]}, 1'b1, 1'b0, 1'b0);
    end
    chk("pre_clr_seen", 32'(o_seen), 32'h00FF);
    step(4'h1, 4'h1, 4'h1, 4'h1, 1'b1, 1'b1, 1'b0);
    chk("clr_seen", 32'(o_seen), 32'h0);
    chk("clr_hi_count", 32'(o_hi), 32'h0);
    chk("clr_f_q", 32'(o_fq), 32'h1);
    chk("clr_out_valid", 32'(o_ov), 32'h1);

    // Saturation of the 2-bit counter
    step(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(4'h1, 4'h1, 4'h1, 4'h1, 1'b1, 1'b0, 1'b0);
      chk("sat_sequence", 32'(s_hi), 32'(sat_exp[i]));
    end

    // Multi-lane independence
    step(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    step(4'hF, 4'hF, 4'hF, 4'h5, 1'b1, 1'b0, 1'b0);
    chk("lanes_f", 32'(w_f), 32'h5);
    chk("lanes_f_q", 32'(w_fq), 32'h5);
    chk("lanes_seen", 32'(w_seen), 32'h8000);

    // Mixed lane patterns
    for (int i = 0; i < 12; i++) begin
      step(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/and4_gate.md
Name:
and4_gate

Overview:
- Four-input AND primitive with a registered output stage and built-in truth-table coverage, replicated across LANES independent lanes.
- Combinational output f = a & b & c & d per lane, plus a one-cycle registered copy qualified by a valid strobe.
- Lane 0 also keeps a sticky 16-entry minterm-coverage vector and a saturating count of accepted vectors that produced f=1, so exhaustive-sweep self-checks need no external scoreboard.
- Used as a leaf gate in datapath glue and as a bring-up sanity block.

Parameters:
- LANES, 1, number of independent 4-input AND lanes (>=1).
- CNT_W, 16, width of the hi_count saturating counter (>=2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  input vector qualifier for the registered path, coverage and counter
- clr  input  1  synchronous clear of seen, all_seen and hi_count only
- a  input  LANES  operand a, bit i belongs to lane i
- b  input  LANES  operand b
- c  input  LANES  operand c
- d  input  LANES  operand d
- f  output  LANES  combinational AND, f[i] = a[i]&b[i]&c[i]&d[i]
- f_q  output  LANES  registered AND of the last accepted vector
- out_valid  output  1  registered in_valid, aligned with f_q
- seen  output  16  lane-0 sticky minterm coverage; bit index = {a[0],b[0],c[0],d[0]} (a is MSB)
- all_seen  output  1  registered; 1 when seen == 16'hFFFF
- hi_count  output  CNT_W  saturating count of accepted lane-0 vectors with f[0]=1

Behaviour:
- f is purely combinational, with zero latency and no dependence on clk, rst or in_valid.
- f is 1 only when all four inputs of the lane are 1. X or Z on any input propagates per standard & semantics.
- Reset (rst=1 at a clk edge): f_q=0, out_valid=0, seen=0, all_seen=0, hi_count=0. rst has priority over clr and in_valid.
- Registered path:
  - On each edge with rst=0, out_valid <= in_valid.
  - If in_valid=1, f_q <= a&b&c&d (latency 1 cycle).
  - If in_valid=0, f_q holds its previous value.
- Coverage:
  - On an edge with rst=0, clr=0 and in_valid=1, seen[{a[0],b[0],c[0],d[0]}] <= 1.
  - Bits are never cleared except by rst or clr.
- all_seen <= (next value of seen == 16'hFFFF). It therefore rises in the same cycle the last missing minterm is recorded.
- Counter:
  - On an edge with rst=0, clr=0, in_valid=1 and f[0]=1, hi_count increments by 1.
  - It saturates at 2^CNT_W-1 and never wraps.
- clr=1 with rst=0: seen, all_seen and hi_count go to 0 on that edge, and the vector presented in that cycle is not recorded.
- clr does not affect f_q or out_valid. That path still captures the vector if in_valid=1.
- Lanes 1..LANES-1 affect only their own f and f_q bits. They have no coverage or counter.
- Reset mid-sweep discards all coverage. The sweep must restart for all_seen to assert.

Test Plan:
- Exhaustive sweep, LANES=1: apply {a,b,c,d} = 0000..1111 in ascending order, one vector per 10 ns, in_valid=1. Required: f=0 for the first 15 vectors and f=1 only for 1111; f_q follows one cycle later; after the last vector seen=16'hFFFF, all_seen=1, hi_count=1.
- Reset mid-sweep: assert rst after vector 0111. Required: the next edge gives f_q=0, out_valid=0, seen=0, hi_count=0; f still tracks the inputs combinationally during reset.
- Valid gating: hold a=b=c=d=1 with in_valid=0 for 5 cycles, then in_valid=1 for 3 cycles. Required: f=1 throughout; hi_count=3; f_q stays 0 until one cycle after in_valid rises.
- Clear vs. capture: with seen=16'h00FF, apply 1111 with in_valid=1 and clr=1. Required: seen=0, hi_count=0, f_q=1, out_valid=1.
- Saturation, CNT_W=2: apply 1111 valid for 6 cycles. Required: hi_count reads 1,2,3,3,3,3.
- Multi-lane, LANES=4: a=b=c=4'b1111, d=4'b0101. Required: f=4'b0101; f_q=4'b0101 one cycle later; lane-0 coverage records minterm 15 only.
